muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 1, giving multiply latency in cycles (legal 1..4).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request; sampled only when idle.
REQ-005 SHALL have port op  input  3  operation: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6/7 reserved.
REQ-006 SHALL have port a  input  32  rs operand (dividend, multiplicand, or MTHI/MTLO source).
REQ-007 SHALL have port b  input  32  rt operand (divisor or multiplier).
REQ-008 SHALL have port cancel  input  1  pipeline flush; aborts any operation.
REQ-009 SHALL have port busy  output  1  operation in progress.
REQ-010 SHALL have port stall_req  output  1  combinational pipeline stall request.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port hi_o  output  32  HI result to the HI/LO register.
REQ-013 SHALL have port lo_o  output  32  LO result to the HI/LO register.
REQ-014 SHALL have port we_o  output  2  HI/LO write enable: bit1 HI, bit0 LO.

Function
REQ-015 SHALL implement FSM IDLE, MUL, DIV, DONE: IDLE->MUL on accepted MULT/MULTU; IDLE->DIV on accepted DIV/DIVU; IDLE->DONE on accepted MTHI/MTLO; MUL->DONE after MUL_CYCLES cycles; DIV->DONE after 33 cycles; DONE->IDLE unconditionally.
REQ-016 SHALL accept start only in IDLE with cancel low and op 0..5; otherwise start is ignored.
REQ-017 SHALL latch a, b and op on the accepting edge; later operand changes have no effect.
REQ-018 SHALL assert done and we_o only in DONE, for exactly one cycle, N edges after the accepting edge: N=1 MTHI/MTLO, N=MUL_CYCLES+1 multiply, N=34 divide.
REQ-019 SHALL drive we_o 2'b11 for multiply/divide, 2'b10 for MTHI, 2'b01 for MTLO, and 2'b00 outside DONE.
REQ-020 SHALL produce for MULT the signed 64-bit product; MULTU the unsigned product; {hi_o,lo_o} = product.
REQ-021 SHALL divide with a radix-2 restoring core: 32 iterations on magnitudes, then one sign-fix cycle.
REQ-022 SHALL, for DIV/DIVU, set lo_o = quotient, hi_o = remainder; the quotient is truncated toward zero, and the remainder takes the dividend's sign.
REQ-023 SHALL give for divide-by-zero lo_o=32'hFFFFFFFF, hi_o=a, with the same 34-cycle latency.
REQ-024 SHALL give for DIV 0x80000000 / 0xFFFFFFFF lo_o=32'h80000000, hi_o=0.
REQ-025 SHALL set hi_o=a for MTHI and lo_o=a for MTLO; the unused half holds its value.
REQ-026 SHALL hold hi_o/lo_o between results; consumers qualify them with we_o.
REQ-027 SHALL drive busy high in MUL and DIV, and low in IDLE and DONE.
REQ-028 SHALL drive stall_req = busy OR (start AND idle AND ~cancel AND op in 0..3).
REQ-029 SHALL, on cancel high in any state, enter IDLE on the next edge, suppress done/we_o, and leave hi_o/lo_o unchanged; cancel has priority over start.
REQ-030 SHALL accept a new start in the cycle after DONE; back-to-back operations need no idle gap beyond DONE.

Reset
REQ-031 SHALL, while rst low, asynchronously force IDLE, busy=0, done=0, we_o=0, hi_o=0, lo_o=0, and clear the iteration counter.
REQ-032 SHALL, on reset mid-operation, produce no partial write; the first post-reset cycle is IDLE.

Structure
REQ-033 SHALL place op encodings, FSM state enum, DIV_ITERS=32 and the we_o codes in shared package muldiv_pkg.
REQ-034 SHALL isolate the iterative divider datapath in sub-module div_radix2 (load, step, done, quotient, remainder); multiply stays inline.

Verification
REQ-035 SHALL check: MULT a=0xFFFFFFFE, b=3, MUL_CYCLES=1 -> 2 edges later done=1, we_o=11, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA.
REQ-036 SHALL check: DIV a=-7 (0xFFFFFFF9), b=2 -> edge 34 lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; busy high edges 1-33; stall_req high from the start cycle.
REQ-037 SHALL check: DIVU a=100, b=0 -> lo_o=0xFFFFFFFF, hi_o=100, we_o=11 at edge 34.
REQ-038 SHALL check: MTLO a=0x12345678 -> next cycle we_o=01, lo_o=0x12345678, hi_o unchanged.
REQ-039 SHALL check: DIV started, cancel at edge 10 -> IDLE at edge 11, no done/we_o ever; new MULTU 5x6 then yields lo_o=30, hi_o=0.
REQ-040 SHALL check: rst low at iteration 20 of DIV -> all outputs 0 immediately; start while busy (ignored) also covered.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and helpers for the multiply/divide unit
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_e;

  localparam int DIV_ITERS = 32;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_LO   = 2'b01;
  localparam logic [1:0] WE_HI   = 2'b10;
  localparam logic [1:0] WE_BOTH = 2'b11;

  function automatic logic [1:0] we_code(input logic [2:0] o);
    case (o)
      OP_MTHI: return WE_HI;
      OP_MTLO: return WE_LO;
      default: return WE_BOTH;
    endcase
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_div_radix2.sv
// rtl/muldiv_unit_div_radix2.sv - radix-2 restoring divider on unsigned magnitudes
module div_radix2
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] shifted;
  logic [31:0] diff;
  logic        fits;

  assign done      = (cnt_q == 6'(DIV_ITERS));
  assign quotient  = quo_q;
  assign remainder = rem_q;

  // The shifted partial remainder can reach 33 bits; once it fits, the difference is below 2^32.
  assign shifted = {rem_q, quo_q[31]};
  assign fits    = (shifted >= {1'b0, dvs_q});
  assign diff    = shifted[31:0] - dvs_q;

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = '0;
    end else if (step && !done) begin
      rem_d = fits ? diff : shifted[31:0];
      quo_d = {quo_q[30:0], fits};
      cnt_d = cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - HI/LO multiply/divide unit with cancel and pipeline stall request
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [1:0]  we_o
);

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  mcnt_q, mcnt_d;

  logic        idle, accept, div_load, div_done;
  logic [31:0] quo, rem, q_fix, r_fix;
  logic [63:0] ma, mb, product;
  logic        mul_signed, div_signed_q;

  assign idle      = (state_q == ST_IDLE);
  assign accept    = start && idle && !cancel && (op <= 3'd5);
  assign busy      = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign stall_req = busy || (start && idle && !cancel && !op[2]);
  assign done      = (state_q == ST_DONE) && !cancel;
  assign we_o      = done ? we_code(op_q) : WE_NONE;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;

  // Sign-extending to 64 bits lets one unsigned multiplier serve MULT and MULTU.
  assign mul_signed = (op_q == OP_MULT);
  assign ma         = {{32{mul_signed & a_q[31]}}, a_q};
  assign mb         = {{32{mul_signed & b_q[31]}}, b_q};
  assign product    = ma * mb;

  assign div_load = accept && ((op == OP_DIV) || (op == OP_DIVU));

  div_radix2 u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .step      (state_q == ST_DIV),
    .dividend  (abs32(a, op == OP_DIV)),
    .divisor   (abs32(b, op == OP_DIV)),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem)
  );

  // Sign fix: quotient truncates toward zero, remainder follows the dividend.
  assign div_signed_q = (op_q == OP_DIV);
  always_comb begin
    q_fix = (div_signed_q && (a_q[31] ^ b_q[31])) ? -quo : quo;
    r_fix = (div_signed_q && a_q[31]) ? -rem : rem;
    if (b_q == '0) begin
      q_fix = '1;
      r_fix = a_q;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcnt_d  = mcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d    = a;
          b_d    = b;
          op_d   = op;
          mcnt_d = '0;
          case (op)
            OP_MULT, OP_MULTU: state_d = ST_MUL;
            OP_DIV, OP_DIVU:   state_d = ST_DIV;
            OP_MTHI: begin
              hi_d    = a;
              state_d = ST_DONE;
            end
            default: begin
              lo_d    = a;
              state_d = ST_DONE;
            end
          endcase
        end
      end
      ST_MUL: begin
        if (mcnt_q == 2'(MUL_CYCLES - 1)) begin
          {hi_d, lo_d} = product;
          state_d      = ST_DONE;
        end else begin
          mcnt_d = mcnt_q + 2'd1;
        end
      end
      ST_DIV: begin
        if (div_done) begin
          hi_d    = r_fix;
          lo_d    = q_fix;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (cancel) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcnt_q  <= mcnt_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against a transaction-level model
module tb_muldiv_unit;

  localparam int MC = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cancel = 1'b0;
  logic        busy, stall_req, done;
  logic [31:0] hi_o, lo_o;
  logic [1:0]  we_o;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.MUL_CYCLES(MC)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .cancel    (cancel),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .we_o      (we_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model state: edges left before the result lands, and whether we sit in the result cycle.
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic [1:0]  m_we = '0;
  int          m_n = 0;

  function automatic void ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] cur_hi, input logic [31:0] cur_lo,
                                 output logic [31:0] rh, output logic [31:0] rl,
                                 output logic [1:0] rwe, output int n);
    longint sx, sy, sp, sq, sr;
    longint unsigned ux, uy, up;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    rh = cur_hi;
    rl = cur_lo;
    rwe = 2'b11;
    n = 34;
    case (o)
      3'd0: begin sp = sx * sy; rh = sp[63:32]; rl = sp[31:0]; n = MC + 1; end
      3'd1: begin up = ux * uy; rh = up[63:32]; rl = up[31:0]; n = MC + 1; end
      3'd2: begin
        if (y == 0) begin rl = 32'hFFFFFFFF; rh = x; end
        else begin sq = sx / sy; sr = sx % sy; rl = sq[31:0]; rh = sr[31:0]; end
      end
      3'd3: begin
        if (y == 0) begin rl = 32'hFFFFFFFF; rh = x; end
        else begin rl = 32'(ux / uy); rh = 32'(ux % uy); end
      end
      3'd4: begin rh = x; rwe = 2'b10; n = 1; end
      default: begin rl = x; rwe = 2'b01; n = 1; end
    endcase
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_left = 0; m_done = 0; m_hi = '0; m_lo = '0; m_we = '0;
    end else if (cancel) begin
      m_left = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; m_done = 1; end
    end else if (start && op <= 3'd5) begin
      ref_op(op, a, b, m_hi, m_lo, p_hi, p_lo, m_we, m_n);
      m_left = m_n - 1;
      if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; m_done = 1; end
    end
  end

  logic       e_busy, e_done, e_stall;
  logic [1:0] e_we;
  initial forever begin
    @(negedge clk);
    e_busy  = (m_left > 0);
    e_done  = m_done && !cancel;
    e_we    = e_done ? m_we : 2'b00;
    e_stall = e_busy || (start && m_left == 0 && !m_done && !cancel && op <= 3'd3);
    chk("cmp_busy", busy, e_busy);
    chk("cmp_done", done, e_done);
    chk("cmp_we", we_o, e_we);
    chk("cmp_stall", stall_req, e_stall);
    chk("cmp_hi", hi_o, m_hi);
    chk("cmp_lo", lo_o, m_lo);
  end

  task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int g = 0;
    while (!(m_left == 0 && !m_done) && g < 100) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 100) chk("launch_idle_timeout", 1, 0);
    start = 1; op = o; a = x; b = y; cancel = 0;
    #1 chk("stall_at_start", stall_req, (o <= 3'd3));
    @(posedge clk); #1;
    start = 0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1 rst = 0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", we_o, 0);
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    @(posedge clk); #1 rst = 1;

    launch(3'd0, 32'hFFFFFFFE, 32'd3);
    @(negedge clk);
    chk("mult_busy_e1", busy, 1);
    chk("mult_done_e1", done, 0);
    @(posedge clk); @(negedge clk);
    chk("mult_done", done, 1);
    chk("mult_we", we_o, 2'b11);
    chk("mult_hi", hi_o, 32'hFFFFFFFF);
    chk("mult_lo", lo_o, 32'hFFFFFFFA);

    launch(3'd2, 32'hFFFFFFF9, 32'd2);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      chk("div_busy", busy, 1);
      chk("div_not_done", done, 0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("div_done", done, 1);
    chk("div_busy_off", busy, 0);
    chk("div_we", we_o, 2'b11);
    chk("div_lo", lo_o, 32'hFFFFFFFD);
    chk("div_hi", hi_o, 32'hFFFFFFFF);

    launch(3'd3, 32'd100, 32'd0);
    repeat (32) @(posedge clk);
    @(negedge clk);
    chk("divu0_early", done, 0);
    @(posedge clk); @(negedge clk);
    chk("divu0_done", done, 1);
    chk("divu0_we", we_o, 2'b11);
    chk("divu0_lo", lo_o, 32'hFFFFFFFF);
    chk("divu0_hi", hi_o, 32'd100);

    launch(3'd5, 32'h12345678, 32'd0);
    @(negedge clk);
    chk("mtlo_done", done, 1);
    chk("mtlo_we", we_o, 2'b01);
    chk("mtlo_lo", lo_o, 32'h12345678);
    chk("mtlo_hi", hi_o, 32'd100);

    launch(3'd2, 32'h80000000, 32'hFFFFFFFF);
    repeat (33) @(posedge clk);
    @(negedge clk);
    chk("divmin_done", done, 1);
    chk("divmin_lo", lo_o, 32'h80000000);
    chk("divmin_hi", hi_o, 32'h0);

    launch(3'd2, $urandom, 32'd7);
    repeat (3) @(posedge clk);
    #1 start = 1; op = 3'd4; a = 32'hDEADBEEF;
    @(posedge clk); #1 start = 0;
    chk("busy_ignores_start", busy, 1);
    repeat (5) @(posedge clk);
    #1 cancel = 1;
    @(posedge clk); #1 cancel = 0;
    chk("cancel_idle", busy, 0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("cancel_no_done", done, 0);
      chk("cancel_no_we", we_o, 0);
    end
    chk("cancel_hi_kept", hi_o, 32'h0);
    chk("cancel_lo_kept", lo_o, 32'h80000000);
    launch(3'd1, 32'd5, 32'd6);
    @(posedge clk); @(negedge clk);
    chk("multu_done", done, 1);
    chk("multu_lo", lo_o, 32'd30);
    chk("multu_hi", hi_o, 32'd0);

    launch(3'd2, $urandom, $urandom | 32'd1);
    repeat (20) @(posedge clk);
    #3 rst = 0;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_we", we_o, 0);
    chk("rstmid_hi", hi_o, 0);
    chk("rstmid_lo", lo_o, 0);
    chk("rstmid_stall", stall_req, 0);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    chk("postrst_idle", busy, 0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("postrst_no_done", done, 0);
    end

    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      start  = ($urandom_range(0, 1) == 0);
      op     = 3'($urandom_range(0, 7));
      a      = pick32();
      b      = ($urandom_range(0, 7) == 0) ? 32'h0 : pick32();
      cancel = ($urandom_range(0, 39) == 0);
      if (!rst) rst = 1;
      else if ($urandom_range(0, 599) == 0) rst = 0;
    end
    @(posedge clk); #1;
    start = 0; cancel = 0; rst = 1;
    repeat (40) @(posedge clk);
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
